// File: rtl/demorgan_sweep.sv
// Self-test sequencer for an external De Morgan gate stage: sweeps {A,B} over all
// four vectors PASSES times and counts mismatches. Optional DEMORGAN_SWEEP_ERRLOG_EN
// adds a record of the first failing vector.
module demorgan_sweep #(
  parameter int PASSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       nAandnB,
  input  logic       npAorB,
  output logic       busy,
  output logic       done,
  output logic [7:0] chk_cnt,
  output logic [7:0] err_cnt,
  output logic       err_flag
`ifdef DEMORGAN_SWEEP_ERRLOG_EN
  ,
  output logic [1:0] first_err,
  output logic       first_err_vld
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_e;

  localparam logic [3:0] LastPass = 4'(PASSES - 1);

  state_e      state_q;
  logic [1:0]  vec_q;
  logic [3:0]  pass_q;
  logic        a_q, b_q, busy_q, done_q;
  logic [7:0]  chk_q, err_q;
  logic        flag_q;

  logic        expected, mismatch;
  logic [7:0]  chk_d, err_d;
  logic [1:0]  vec_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    expected = ~(a_q | b_q);
    mismatch = (nAandnB != expected) || (npAorB != expected);
    chk_d    = (chk_q == 8'hFF) ? chk_q : chk_q + 8'd1;
    err_d    = err_q;
    if (mismatch && err_q != 8'hFF) err_d = err_q + 8'd1;
    vec_d    = vec_q + 2'd1;
  end

`ifdef DEMORGAN_SWEEP_ERRLOG_EN
  logic [1:0] ferr_q;
  logic       fvld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_q <= 2'b00;
      fvld_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      ferr_q <= 2'b00;
      fvld_q <= 1'b0;
    end else if (state_q == S_CHECK && mismatch && !fvld_q) begin
      ferr_q <= {a_q, b_q};
      fvld_q <= 1'b1;
    end
  end

  assign first_err     = ferr_q;
  assign first_err_vld = fvld_q;
`endif

  // Outputs are registered: each transition loads the values of the state it enters.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 2'b00;
      pass_q  <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      chk_q   <= 8'd0;
      err_q   <= 8'd0;
      flag_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DRIVE;
            vec_q   <= 2'b00;
            pass_q  <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b1;
            chk_q   <= 8'd0;
            err_q   <= 8'd0;
            flag_q  <= 1'b0;
          end
        end
        S_DRIVE: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          chk_q <= chk_d;
          err_q <= err_d;
          if (mismatch) flag_q <= 1'b1;
          if (vec_q != 2'b11) begin
            state_q <= S_DRIVE;
            vec_q   <= vec_d;
            {a_q, b_q} <= vec_d;
          end else if (pass_q < LastPass) begin
            state_q <= S_DRIVE;
            pass_q  <= pass_q + 4'd1;
            vec_q   <= 2'b00;
            {a_q, b_q} <= 2'b00;
          end else begin
            state_q <= S_DONE;
            {a_q, b_q} <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign chk_cnt  = chk_q;
  assign err_cnt  = err_q;
  assign err_flag = flag_q;

endmodule

// File: tb/tb_demorgan_sweep.sv
// Bench for demorgan_sweep: two instances (PASSES=1 and PASSES=3) each driving a
// gate model with per-vector fault masks; table, random and hand-written sequences.
module tb_demorgan_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  int         psel;
  logic [3:0] fault_a, fault_n;
  int         total = 0;
  int         bad   = 0;

  logic       A1, B1, nab1, npab1, busy1, done1, flag1;
  logic [7:0] chk1, err1;
  logic       A3, B3, nab3, npab3, busy3, done3, flag3;
  logic [7:0] chk3, err3;
  logic       start1, start3;

  // Gate stage model: correct De Morgan outputs, inverted where a fault mask bit is set.
  assign nab1   = (~A1 & ~B1) ^ fault_a[{A1, B1}];
  assign npab1  = ~(A1 | B1)  ^ fault_n[{A1, B1}];
  assign nab3   = (~A3 & ~B3) ^ fault_a[{A3, B3}];
  assign npab3  = ~(A3 | B3)  ^ fault_n[{A3, B3}];
  assign start1 = start && (psel == 1);
  assign start3 = start && (psel == 3);

`ifdef DEMORGAN_SWEEP_ERRLOG_EN
  logic [1:0] fe1, fe3;
  logic       fv1, fv3;
`endif

  demorgan_sweep #(.PASSES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
    .nAandnB(nab1), .npAorB(npab1), .busy(busy1), .done(done1),
    .chk_cnt(chk1), .err_cnt(err1), .err_flag(flag1)
`ifdef DEMORGAN_SWEEP_ERRLOG_EN
    , .first_err(fe1), .first_err_vld(fv1)
`endif
  );

  demorgan_sweep #(.PASSES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .A(A3), .B(B3),
    .nAandnB(nab3), .npAorB(npab3), .busy(busy3), .done(done3),
    .chk_cnt(chk3), .err_cnt(err3), .err_flag(flag3)
`ifdef DEMORGAN_SWEEP_ERRLOG_EN
    , .first_err(fe3), .first_err_vld(fv3)
`endif
  );

  logic       s_a, s_b, s_busy, s_done, s_flag;
  logic [7:0] s_chk, s_err;
`ifdef DEMORGAN_SWEEP_ERRLOG_EN
  logic [1:0] s_fe;
  logic       s_fv;
`endif

  always_comb begin
    s_a = A1; s_b = B1; s_busy = busy1; s_done = done1;
    s_flag = flag1; s_chk = chk1; s_err = err1;
`ifdef DEMORGAN_SWEEP_ERRLOG_EN
    s_fe = fe1; s_fv = fv1;
`endif
    if (psel == 3) begin
      s_a = A3; s_b = B3; s_busy = busy3; s_done = done3;
      s_flag = flag3; s_chk = chk3; s_err = err3;
`ifdef DEMORGAN_SWEEP_ERRLOG_EN
      s_fe = fe3; s_fv = fv3;
`endif
    end
  end

  typedef struct {
    int         p;
    logic [3:0] fa;
    logic [3:0] fn;
    int         poke;
    int         exp_chk;
    int         exp_err;
    logic       exp_flag;
    logic [1:0] exp_first;
    logic       exp_vld;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: every pass checks all four vectors, so each faulty vector
  // contributes once per pass; the first failure is the lowest faulty vector.
  function automatic int model_err(input int p, input logic [3:0] m);
    int n;
    n = p * $countones(m);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic logic [1:0] model_first(input logic [3:0] m);
    for (int v = 0; v < 4; v++) if (m[v]) return 2'(v);
    return 2'b00;
  endfunction

  task automatic run_sweep(input vec_t t, input string tag);
    int seq_bad = 0;
    psel = t.p; fault_a = t.fa; fault_n = t.fn;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int j = 0; j < 8 * t.p; j++) begin
      if ({s_a, s_b} != 2'((j / 2) % 4) || !s_busy || s_done || s_chk != 8'(j / 2))
        seq_bad++;
      start = (j == t.poke);
      tick;
    end
    start = 1'b0;
    check($sformatf("%s seq", tag), seq_bad, 0);
    check($sformatf("%s done", tag), s_done, 1);
    check($sformatf("%s busy", tag), s_busy, 0);
    check($sformatf("%s ab", tag), {s_a, s_b}, 0);
    check($sformatf("%s chk", tag), s_chk, t.exp_chk);
    check($sformatf("%s err", tag), s_err, t.exp_err);
    check($sformatf("%s flag", tag), s_flag, t.exp_flag);
`ifdef DEMORGAN_SWEEP_ERRLOG_EN
    check($sformatf("%s first", tag), s_fe, t.exp_first);
    check($sformatf("%s first_vld", tag), s_fv, t.exp_vld);
`endif
    tick;
    check($sformatf("%s done width", tag), s_done, 0);
    repeat (3) tick;
    check($sformatf("%s hold", tag), {s_busy, s_chk, s_err, s_flag},
          {1'b0, 8'(t.exp_chk), 8'(t.exp_err), t.exp_flag});
  endtask

  initial begin
    int   n_done, b2b_bad, wait_n, rst_bad;
    vec_t r;
    logic [3:0] m;

    tbl[0] = '{1, 4'b0000, 4'b0000, -1, 4,  0, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{1, 4'b0000, 4'b0001, -1, 4,  1, 1'b1, 2'd0, 1'b1};
    tbl[2] = '{3, 4'b0000, 4'b0000,  5, 12, 0, 1'b0, 2'd0, 1'b0};
    tbl[3] = '{3, 4'b1000, 4'b0100, -1, 12, 6, 1'b1, 2'd2, 1'b1};
    tbl[4] = '{1, 4'b1111, 4'b0000,  3, 4,  4, 1'b1, 2'd0, 1'b1};
    tbl[5] = '{1, 4'b0110, 4'b0110,  7, 4,  2, 1'b1, 2'd1, 1'b1};

    rst = 1'b1; start = 1'b1; psel = 1; fault_a = '0; fault_n = '0;
    repeat (2) tick;
    check("reset dut1", {A1, B1, busy1, done1, chk1, err1, flag1}, 0);
    check("reset dut3", {A3, B3, busy3, done3, chk3, err3, flag3}, 0);
    rst = 1'b0; start = 1'b0;
    tick;
    check("idle after reset", {A1, B1, busy1, done1}, 0);

    for (int i = 0; i < 6; i++) run_sweep(tbl[i], $sformatf("tbl%0d", i));

    // Reset during the CHECK cycle of vector 10 aborts with no done pulse.
    psel = 1; fault_a = 4'b0001; fault_n = 4'b0000;
    start = 1'b1; tick; start = 1'b0;
    repeat (5) tick;
    check("pre-rst ab", {s_a, s_b}, 2);
    check("pre-rst err", s_err, 1);
    rst = 1'b1; tick; rst = 1'b0;
    check("post-rst outs", {s_a, s_b, s_busy, s_done, s_chk, s_err, s_flag}, 0);
    rst_bad = 0;
    repeat (12) begin tick; if (s_done || s_busy) rst_bad++; end
    check("no done after abort", rst_bad, 0);
    r = '{1, 4'b0000, 4'b0000, -1, 4, 0, 1'b0, 2'd0, 1'b0};
    run_sweep(r, "post-rst clean");

    // Randomized runs checked against the behavioural model.
    for (int i = 0; i < 16; i++) begin
      r.p  = ($urandom_range(0, 1) == 0) ? 1 : 3;
      r.fa = 4'($urandom_range(0, 15));
      r.fn = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      r.poke = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 8 * r.p - 1));
      m = r.fa | r.fn;
      r.exp_chk   = 4 * r.p;
      r.exp_err   = model_err(r.p, m);
      r.exp_flag  = (m != 4'b0000);
      r.exp_first = model_first(m);
      r.exp_vld   = (m != 4'b0000);
      run_sweep(r, $sformatf("rnd%0d", i));
    end

    // start held high: done every 10 cycles, each one cycle wide.
    psel = 1; fault_a = '0; fault_n = '0;
    start = 1'b1; tick;
    b2b_bad = 0; n_done = 0;
    for (int n = 1; n <= 30; n++) begin
      tick;
      if (s_done != (n >= 8 && (n - 8) % 10 == 0)) b2b_bad++;
      if (s_done) begin
        n_done++;
        if (s_chk != 8'd4) b2b_bad++;
      end
    end
    start = 1'b0;
    check("b2b pattern", b2b_bad, 0);
    check("b2b done count", n_done, 3);
    wait_n = 0;
    while ((s_busy || s_done) && wait_n < 40) begin tick; wait_n++; end
    check("b2b drain", wait_n < 40, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demorgan_sweep.md
DEMORGAN_SWEEP -- requirements
Module: demorgan_sweep

Interface
REQ-001 SHALL have parameter PASSES, default 1, number of full 4-vector sweeps per run, legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have port A  output  1  stimulus bit A to the downstream De Morgan gate stage.
REQ-006 SHALL have port B  output  1  stimulus bit B to the downstream De Morgan gate stage.
REQ-007 SHALL have port nAandnB  input  1  (~A)&(~B) returned from the gate stage.
REQ-008 SHALL have port npAorB  input  1  ~(A|B) returned from the gate stage.
REQ-009 SHALL have port busy  output  1  high in DRIVE and CHECK.
REQ-010 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-011 SHALL have port chk_cnt  output  8  vectors checked this run.
REQ-012 SHALL have port err_cnt  output  8  mismatching vectors this run, saturating.
REQ-013 SHALL have port err_flag  output  1  sticky, set on any mismatch this run.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, CHECK, DONE; the encoding is free.
REQ-015 IDLE: A=B=0; busy=0. A start=1 moves the FSM to DRIVE, sets vec=2'b00 and pass=0, and clears chk_cnt, err_cnt and err_flag in the same edge.
REQ-016 DRIVE: {A,B}=vec; the FSM SHALL move to CHECK unconditionally after 1 cycle.
REQ-017 CHECK: {A,B} SHALL hold at vec. The FSM SHALL sample nAandnB and npAorB. expected = ~(A|B). A mismatch is nAandnB!=expected or npAorB!=expected.
REQ-018 On each CHECK edge, chk_cnt SHALL increment, saturating at 255. err_cnt SHALL increment on a mismatch, saturating at 255. err_flag SHALL set on a mismatch.
REQ-019 CHECK transitions: if vec!=2'b11, vec increments and the FSM goes to DRIVE. If vec==2'b11 and pass<PASSES-1, pass increments, vec wraps to 2'b00 and the FSM goes to DRIVE. Otherwise the FSM goes to DONE.
REQ-020 DONE: done=1 for exactly 1 cycle, A=B=0, then IDLE. start is ignored in DONE.
REQ-021 start SHALL be ignored while busy=1. No restart and no counter clear.
REQ-022 Latency: for start sampled at edge k, done SHALL be high in the cycle after edge k+8*PASSES. chk_cnt at done SHALL equal 4*PASSES.
REQ-023 chk_cnt, err_cnt and err_flag SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-024 With rst=1 at a rising edge: state=IDLE, A=B=0, busy=0, done=0, chk_cnt=0, err_cnt=0, err_flag=0, vec=0, pass=0.
REQ-025 rst SHALL override start and any in-progress run, including mid-CHECK and the DONE cycle. A run aborted by reset SHALL produce no done pulse.

Configuration
REQ-026 Macro DEMORGAN_SWEEP_ERRLOG_EN.
- Defined: adds output first_err  2, the {A,B} of the first mismatching vector this run, and output first_err_vld  1. Both are 0 on reset and on an accepted start. They are captured once per run.
- Undefined: these ports and their logic SHALL be absent. All other behaviour is unchanged.

Verification
REQ-027 Correct gate stage, PASSES=1, start pulse -> A,B sequence 00,01,10,11, each held 2 cycles; done at cycle 9; chk_cnt=4, err_cnt=0, err_flag=0.
REQ-028 Gate stage with npAorB stuck at 0, PASSES=1 -> mismatch only at vec 00; err_cnt=1, err_flag=1; with macro defined, first_err=2'b00 and first_err_vld=1.
REQ-029 PASSES=3 with a correct gate stage -> done at cycle 25, chk_cnt=12; start pulsed at cycle 5 is ignored and causes no restart.
REQ-030 rst asserted for one edge in the CHECK cycle of vec 10 -> next cycle is IDLE with all outputs 0 and no done pulse; a following start runs a full clean sweep.
REQ-031 start held high continuously -> runs back-to-back. Each run is separated by one DONE cycle and one IDLE cycle, and each done pulse is one cycle long.
